// File: rtl/divider.sv
// 64-by-6 unsigned restoring divider, one quotient bit per clock, MSB first.
// Define DIVIDER_ZERO_SHORTCUT_EN to finish a divide-by-zero one cycle after start.
module divider (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_start,
  input  logic        op_clear,
  input  logic [63:0] dividend,
  input  logic [5:0]  divisor,
  output logic        op_done,
  output logic [63:0] quotient,
  output logic [5:0]  remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      r_state;
  logic [5:0]  r_count;
  logic [63:0] r_dvd;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [5:0]  r_dsr;
  logic [5:0]  r_prem;

  logic [6:0]  w_shift;
  logic        w_qbit;
  logic [5:0]  w_diff;
  logic [5:0]  w_prem_next;
  logic [63:0] w_quo_next;

  // The 7-bit trial value can reach 125; once the subtraction succeeds the
  // result is below the divisor, so six bits of the difference are enough.
  always_comb begin
    w_shift     = {r_prem, r_dvd[63]};
    w_qbit      = (w_shift >= {1'b0, r_dsr});
    w_diff      = w_shift[5:0] - r_dsr;
    w_prem_next = w_qbit ? w_diff : w_shift[5:0];
    w_quo_next  = {r_dvd[62:0], w_qbit};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_dvd     <= '0;
      r_dsr     <= '0;
      r_prem    <= '0;
      op_done   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (op_start) begin
            r_dvd   <= dividend;
            r_dsr   <= divisor;
            r_prem  <= '0;
            r_count <= '0;
            r_state <= EXEC;
          end
        end

        EXEC: begin
          if (op_clear) begin
            quotient  <= '0;
            remainder <= '0;
            r_state   <= IDLE;
          end
`ifdef DIVIDER_ZERO_SHORTCUT_EN
          else if (r_dsr == '0) begin
            quotient  <= '1;
            remainder <= r_dvd[5:0];
            div_zero  <= 1'b1;
            op_done   <= 1'b1;
            r_state   <= DONE;
          end
`endif
          else begin
            r_dvd   <= w_quo_next;
            r_prem  <= w_prem_next;
            r_count <= r_count + 6'd1;
            if (r_count == 6'd63) begin
              quotient  <= w_quo_next;
              remainder <= w_prem_next;
              div_zero  <= (r_dsr == '0);
              op_done   <= 1'b1;
              r_state   <= DONE;
            end
          end
        end

        DONE: begin
          if (op_clear) begin
            op_done  <= 1'b0;
            div_zero <= 1'b0;
            r_state  <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: expected results are queued at start and
// compared when op_done rises, together with the start-to-done latency.
module tb_divider;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_start;
  logic        op_clear;
  logic [63:0] dividend;
  logic [5:0]  divisor;
  logic        op_done;
  logic [63:0] quotient;
  logic [5:0]  remainder;
  logic        div_zero;

  divider dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_start (op_start),
    .op_clear (op_clear),
    .dividend (dividend),
    .divisor  (divisor),
    .op_done  (op_done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

`ifdef DIVIDER_ZERO_SHORTCUT_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 64;
`endif

  typedef struct {
    logic [63:0] q;
    logic [5:0]  r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Queue the reference result, then pulse op_start across one rising edge.
  task automatic drive_start(input logic [63:0] a, input logic [5:0] b, input logic with_clear);
    exp_t e;
    e.q   = (b == 6'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / {58'd0, b};
    e.r   = (b == 6'd0) ? a[5:0] : 6'(a % {58'd0, b});
    e.dz  = (b == 6'd0);
    e.lat = (b == 6'd0) ? ZERO_LAT : 64;
    sb.push_back(e);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    op_start = 1'b1;
    op_clear = with_clear;
    @(negedge clk);
    op_start = 1'b0;
    op_clear = 1'b0;
  endtask

  // Count rising edges after the start edge until op_done; -1 on timeout.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (cycles < 200) begin
      @(posedge clk);
      cycles++;
      #1;
      if (op_done === 1'b1) return;
    end
    cycles = -1;
  endtask

  task automatic clear_op();
    @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
  endtask

  // Watch for a spurious op_done over n cycles; returns 1 if one was seen.
  task automatic watch_idle(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (op_done !== 1'b0) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit seen;
    reset_n = 1'b0; op_start = 1'b0; op_clear = 1'b0; dividend = '0; divisor = '0;
    #3;
    n_checks++;
    if ({op_done, div_zero, quotient, remainder} !== 72'd0)
      $display("FAIL reset_outputs: got done=%b dz=%b q=%h r=%h, expected all 0", op_done, div_zero, quotient, remainder);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    watch_idle(10, seen);
    n_checks++;
    if (seen) $display("FAIL reset_no_start: op_done rose without op_start, expected 0");
    else n_pass++;
  endtask

  task automatic test_basic();
    int   cyc;
    exp_t e;
    drive_start(64'd100, 6'd7, 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    n_checks++;
    if (cyc !== e.lat) $display("FAIL basic_latency: got %0d cycles, expected %0d", cyc, e.lat);
    else n_pass++;
    n_checks++;
    if ({quotient, remainder, div_zero} !== {e.q, e.r, e.dz})
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b, expected q=%0d r=%0d dz=%b", quotient, remainder, div_zero, e.q, e.r, e.dz);
    else n_pass++;
    // DONE must hold even while new operands and op_start are presented.
    @(negedge clk);
    op_start = 1'b1; dividend = 64'd5; divisor = 6'd2;
    repeat (5) @(negedge clk);
    op_start = 1'b0;
    n_checks++;
    if ({op_done, quotient, remainder, div_zero} !== {1'b1, e.q, e.r, e.dz})
      $display("FAIL done_hold: got done=%b q=%0d r=%0d dz=%b, expected done=1 q=%0d r=%0d", op_done, quotient, remainder, div_zero, e.q, e.r);
    else n_pass++;
    clear_op();
    n_checks++;
    if ({op_done, div_zero, quotient, remainder} !== {2'b00, e.q, e.r})
      $display("FAIL clear_to_idle: got done=%b dz=%b q=%0d r=%0d, expected done=0 dz=0 q=%0d r=%0d", op_done, div_zero, quotient, remainder, e.q, e.r);
    else n_pass++;
  endtask

  task automatic test_max();
    int   cyc;
    exp_t e;
    drive_start(64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder} !== {e.q, e.r} || cyc !== e.lat)
      $display("FAIL max_result: got q=%h r=%0d lat=%0d, expected q=%h r=%0d lat=%0d", quotient, remainder, cyc, e.q, e.r, e.lat);
    else n_pass++;
    clear_op();
  endtask

  task automatic test_div_zero();
    int   cyc;
    exp_t e;
    drive_start(64'h1234, 6'd0, 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    n_checks++;
    if (cyc !== e.lat) $display("FAIL zero_latency: got %0d cycles, expected %0d", cyc, e.lat);
    else n_pass++;
    n_checks++;
    if ({quotient, remainder, div_zero} !== {e.q, e.r, e.dz})
      $display("FAIL zero_result: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b", quotient, remainder, div_zero, e.q, e.r, e.dz);
    else n_pass++;
    clear_op();
    n_checks++;
    if (div_zero !== 1'b0) $display("FAIL zero_clear: got dz=%b, expected 0", div_zero);
    else n_pass++;
  endtask

  task automatic test_operand_change();
    int   cyc;
    exp_t e;
    drive_start(64'hDEAD_BEEF_0123_4567, 6'd1, 1'b0);
    dividend = 64'h0F0F_0F0F_0F0F_0F0F;
    divisor  = 6'd13;
    wait_done(cyc);
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder} !== {e.q, e.r} || cyc !== e.lat)
      $display("FAIL operand_change: got q=%h r=%0d lat=%0d, expected q=%h r=%0d lat=%0d", quotient, remainder, cyc, e.q, e.r, e.lat);
    else n_pass++;
    clear_op();
  endtask

  task automatic test_reset_mid();
    int   cyc;
    bit   seen;
    exp_t e;
    drive_start(64'd999_999, 6'd37, 1'b0);
    repeat (29) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({op_done, div_zero, quotient, remainder} !== 72'd0)
      $display("FAIL reset_mid_exec: got done=%b dz=%b q=%h r=%h, expected all 0", op_done, div_zero, quotient, remainder);
    else n_pass++;
    void'(sb.pop_front());
    @(negedge clk);
    reset_n = 1'b1;
    watch_idle(100, seen);
    n_checks++;
    if (seen) $display("FAIL reset_mid_no_done: op_done rose after reset, expected 0");
    else n_pass++;
    drive_start(64'd999_999, 6'd37, 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder} !== {e.q, e.r} || cyc !== e.lat)
      $display("FAIL reset_mid_rerun: got q=%0d r=%0d lat=%0d, expected q=%0d r=%0d lat=%0d", quotient, remainder, cyc, e.q, e.r, e.lat);
    else n_pass++;
    clear_op();
  endtask

  task automatic test_abort();
    int   cyc;
    bit   seen;
    exp_t e;
    drive_start(64'd123_456_789, 6'd10, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk);
    #1;
    op_clear = 1'b0;
    n_checks++;
    if ({op_done, div_zero, quotient, remainder} !== 72'd0)
      $display("FAIL abort_outputs: got done=%b dz=%b q=%h r=%h, expected all 0", op_done, div_zero, quotient, remainder);
    else n_pass++;
    void'(sb.pop_front());
    watch_idle(80, seen);
    n_checks++;
    if (seen) $display("FAIL abort_no_done: op_done rose after abort, expected 0");
    else n_pass++;
    drive_start(64'd123_456_789, 6'd10, 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder} !== {e.q, e.r} || cyc !== e.lat)
      $display("FAIL abort_rerun: got q=%0d r=%0d lat=%0d, expected q=%0d r=%0d lat=%0d", quotient, remainder, cyc, e.q, e.r, e.lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int   cyc;
    bit   seen;
    exp_t e;
    // Still in DONE from the previous test: start+clear together must only clear.
    @(negedge clk);
    op_start = 1'b1; op_clear = 1'b1; dividend = 64'd77; divisor = 6'd5;
    @(negedge clk);
    op_start = 1'b0; op_clear = 1'b0;
    watch_idle(80, seen);
    n_checks++;
    if (seen) $display("FAIL start_clear_in_done: op_done rose, expected start to be dropped");
    else n_pass++;
    // In IDLE, start+clear together must start.
    drive_start(64'd77, 6'd5, 1'b1);
    wait_done(cyc);
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder} !== {e.q, e.r} || cyc !== e.lat)
      $display("FAIL start_clear_in_idle: got q=%0d r=%0d lat=%0d, expected q=%0d r=%0d lat=%0d", quotient, remainder, cyc, e.q, e.r, e.lat);
    else n_pass++;
    clear_op();
    for (int i = 0; i < 8; i++) begin
      logic [63:0] a;
      logic [5:0]  b;
      a = {$urandom, $urandom};
      b = (i == 3) ? 6'd0 : 6'($urandom_range(1, 63));
      drive_start(a, b, 1'b0);
      wait_done(cyc);
      e = sb.pop_front();
      n_checks++;
      if ({quotient, remainder, div_zero} !== {e.q, e.r, e.dz} || cyc !== e.lat)
        $display("FAIL random_%0d: %h/%0d got q=%h r=%0d dz=%b lat=%0d, expected q=%h r=%0d dz=%b lat=%0d",
                 i, a, b, quotient, remainder, div_zero, cyc, e.q, e.r, e.dz, e.lat);
      else n_pass++;
      clear_op();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_div_zero();
    test_operand_change();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
